uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares the single UART transmitter among `N_REQ` byte producers, such as the ALU result path, a status reporter and a debug echo. It sits between the requesters and the `start`/`data`/`done` handshake of the TX serializer. It grants one requester at a time, forwards its byte with a one-cycle start pulse, and holds the grant until the serializer reports frame completion or a watchdog expires.

---
 rtl/uart_arb_pkg.sv | 22 ++
 rtl/rr_priority_picker.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 105 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: state encoding and
// the grant-index width helper.
package uart_arb_pkg;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] START     = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;
  localparam logic [1:0] RELEASE   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = IDLE,
    ST_START     = START,
    ST_WAIT_DONE = WAIT_DONE,
    ST_RELEASE   = RELEASE
  } arb_state_t;

  // Width of an index able to address n requesters (never below 1 bit).
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: first requester with req high,
// scanning ptr, ptr+1, ... modulo N_REQ.
module rr_priority_picker
  import uart_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int IDX_WIDTH = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0]     i_req,
  input  logic [IDX_WIDTH-1:0] i_ptr,
  output logic                 o_any,
  output logic [IDX_WIDTH-1:0] o_winner_idx
);

  int                   k;
  logic [IDX_WIDTH-1:0] cand;

  // Scan from the farthest offset down so the nearest match overwrites last.
  always_comb begin
    o_any        = 1'b0;
    o_winner_idx = '0;
    k            = 0;
    cand         = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k    = (int'(i_ptr) + i) % N_REQ;
      cand = IDX_WIDTH'(k);
      if (i_req[cand]) begin
        o_any        = 1'b1;
        o_winner_idx = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the single UART transmitter: grants one requester,
// pulses start, waits for done or watchdog expiry, then acks or reports timeout.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int IDX_WIDTH   = idx_width(N_REQ),
  parameter int TRAMA_SIZE  = 8,
  parameter int TIMEOUT_LEN = 18
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [N_REQ-1:0]              i_req,
  input  logic [N_REQ*TRAMA_SIZE-1:0]   i_data,
  input  logic                          i_tx_done,
  output logic                          o_tx_start,
  output logic [TRAMA_SIZE-1:0]         o_tx_data,
  output logic [N_REQ-1:0]              o_ack,
  output logic [IDX_WIDTH-1:0]          o_grant_idx,
  output logic                          o_busy,
  output logic                          o_timeout,
  output logic [1:0]                    o_state
);

  // Handshake: o_tx_start is a one-cycle pulse, i_tx_done is a one-cycle pulse
  // honoured only in WAIT_DONE; o_ack[k] is a one-cycle pulse in RELEASE and the
  // requester keeps i_req[k] (with stable data) high until it sees that pulse.

  arb_state_t             state, state_nxt;
  logic                   any;
  logic [IDX_WIDTH-1:0]   winner_idx;
  logic [IDX_WIDTH-1:0]   ptr;
  logic [TIMEOUT_LEN-1:0] wd_cnt;
  logic                   wd_expired;
  logic                   served_done;

  rr_priority_picker #(
    .N_REQ     (N_REQ),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_picker (
    .i_req        (i_req),
    .i_ptr        (ptr),
    .o_any        (any),
    .o_winner_idx (winner_idx)
  );

  assign wd_expired = (wd_cnt == {TIMEOUT_LEN{1'b1}});

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (any) state_nxt = ST_START;
      ST_START:     state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (i_tx_done || wd_expired) state_nxt = ST_RELEASE;
      ST_RELEASE:   state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // served_done tracks i_tx_done every WAIT_DONE cycle, so on exit it tells
  // done apart from a bare expiry (done wins when both land together).
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      ptr         <= '0;
      o_grant_idx <= '0;
      o_tx_data   <= '0;
      wd_cnt      <= '0;
      served_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any) begin
            o_grant_idx <= winner_idx;
            o_tx_data   <= i_data[int'(winner_idx)*TRAMA_SIZE +: TRAMA_SIZE];
          end
        end
        ST_START: begin
          wd_cnt      <= '0;
          served_done <= 1'b0;
        end
        ST_WAIT_DONE: begin
          wd_cnt      <= wd_cnt + TIMEOUT_LEN'(1);
          served_done <= i_tx_done;
        end
        ST_RELEASE: begin
          ptr <= (o_grant_idx == IDX_WIDTH'(N_REQ - 1)) ? '0
                                                        : o_grant_idx + IDX_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_tx_start = (state == ST_START);
  assign o_busy     = (state != ST_IDLE);
  assign o_ack      = (state == ST_RELEASE && served_done) ? (N_REQ'(1) << o_grant_idx) : '0;
  assign o_timeout  = (state == ST_RELEASE) && !served_done;
  assign o_state    = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a transaction-level reference
// model (requester table, round-robin pointer, fixed service timeline).
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int IW   = 2;
  localparam int W    = 8;
  localparam int TL   = 4;
  localparam int WD_MAX = (1 << TL) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     i_req;
  logic [N*W-1:0]   i_data;
  logic             i_tx_done;
  logic             o_tx_start;
  logic [W-1:0]     o_tx_data;
  logic [N-1:0]     o_ack;
  logic [IW-1:0]    o_grant_idx;
  logic             o_busy;
  logic             o_timeout;
  logic [1:0]       o_state;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [N-1:0] req_v;
  logic [W-1:0] data_v [N];
  int           ptr_m;

  uart_tx_arbiter #(
    .N_REQ (N), .IDX_WIDTH (IW), .TRAMA_SIZE (W), .TIMEOUT_LEN (TL)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst_n),
    .i_req       (i_req),
    .i_data      (i_data),
    .i_tx_done   (i_tx_done),
    .o_tx_start  (o_tx_start),
    .o_tx_data   (o_tx_data),
    .o_ack       (o_ack),
    .o_grant_idx (o_grant_idx),
    .o_busy      (o_busy),
    .o_timeout   (o_timeout),
    .o_state     (o_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic apply();
    i_req = req_v;
    for (int k = 0; k < N; k++) i_data[k*W +: W] = data_v[k];
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, o_tx_start, 0);
    check({tag, "_data"},  o_tx_data, 0);
    check({tag, "_ack"},   o_ack, 0);
    check({tag, "_grant"}, o_grant_idx, 0);
    check({tag, "_busy"},  o_busy, 0);
    check({tag, "_tmo"},   o_timeout, 0);
  endtask

  // One service, entered at #1 after an IDLE edge with req_v non-zero.
  // done_k: done is driven in the k-th WAIT_DONE cycle (k >= 1); a value past
  // the watchdog limit means no done before expiry.
  task automatic serve(input int done_k, input bit done_in_start,
                       input bit drop, input bit reassert);
    int         win;
    int         rel;
    bit         acked;
    logic [W-1:0] exp_d;
    win   = ref_pick(req_v, ptr_m);
    exp_d = data_v[win];
    acked = (done_k <= WD_MAX + 1);
    rel   = acked ? done_k + 1 : WD_MAX + 2;

    @(posedge clk); #1;
    check("start_pulse", o_tx_start, 1);
    check("grant_idx", o_grant_idx, win);
    check("tx_data", o_tx_data, exp_d);
    check("busy_start", o_busy, 1);
    if (done_in_start) i_tx_done = 1'b1;

    for (int k = 1; k < rel; k++) begin
      @(posedge clk); #1;
      i_tx_done = 1'b0;
      check("wait_no_start", o_tx_start, 0);
      check("wait_no_ack", o_ack, 0);
      check("wait_no_tmo", o_timeout, 0);
      check("wait_busy", o_busy, 1);
      if (drop && k == 1) begin
        req_v[win] = 1'b0;
        apply();
      end
      if (k == done_k) i_tx_done = 1'b1;
    end

    @(posedge clk); #1;
    // a done pulse in RELEASE must be ignored
    i_tx_done = (done_k == rel) ? 1'b1 : 1'b0;
    check("rel_ack", o_ack, acked ? (32'd1 << win) : 32'd0);
    check("rel_tmo", o_timeout, acked ? 0 : 1);
    check("rel_data", o_tx_data, exp_d);
    check("rel_busy", o_busy, 1);
    ptr_m = (win + 1) % N;
    if (acked) begin
      if (reassert && !drop) data_v[win] = W'($urandom);
      else                   req_v[win]  = 1'b0;
    end
    apply();

    @(posedge clk); #1;
    i_tx_done = 1'b0;
    check("idle_busy", o_busy, 0);
    check("idle_ack", o_ack, 0);
    check("idle_tmo", o_timeout, 0);
    check("idle_data_hold", o_tx_data, exp_d);
  endtask

  initial begin
    rst_n     = 1'b0;
    i_tx_done = 1'b0;
    req_v     = '0;
    for (int k = 0; k < N; k++) data_v[k] = '0;
    apply();
    ptr_m = 0;
    #12;
    check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", o_busy, 0);

    // single request
    req_v = 4'b0001; data_v[0] = 8'h5A; apply();
    serve(3, 0, 0, 0);

    // pointer skip: ptr is now 1, grant 3 then 0
    req_v = 4'b1001; data_v[0] = 8'hC3; data_v[3] = 8'h3C; apply();
    serve(2, 0, 0, 0);
    serve(4, 0, 0, 0);

    // fairness with all requesters held
    req_v = 4'b1111;
    for (int k = 0; k < N; k++) data_v[k] = W'(8'h10 + k);
    apply();
    for (int j = 0; j < 5; j++) serve(1 + j, 0, 0, 1);

    // watchdog expiry, then the same requester eventually re-served
    serve(WD_MAX + 5, 0, 0, 1);
    // done on the exact expiry cycle: done wins
    serve(WD_MAX + 1, 0, 0, 1);
    // done during START ignored
    serve(5, 1, 0, 1);
    // done one cycle after expiry lands in RELEASE and is ignored
    serve(WD_MAX + 2, 0, 0, 1);
    // requester drops mid-frame
    serve(3, 0, 1, 0);

    // randomized traffic
    req_v = '0; apply();
    for (int t = 0; t < 40; t++) begin
      int dk;
      for (int k = 0; k < N; k++) begin
        if (!req_v[k] && $urandom_range(0, 2) == 0) begin
          req_v[k] = 1'b1; data_v[k] = W'($urandom);
        end
      end
      if (req_v == '0) begin
        int k0;
        k0 = $urandom_range(0, N - 1);
        req_v[k0] = 1'b1; data_v[k0] = W'($urandom);
      end
      apply();
      dk = ($urandom_range(0, 5) == 0) ? WD_MAX + 1 : $urandom_range(1, WD_MAX + 3);
      serve(dk, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 1) == 1);
    end

    // mid-frame reset
    req_v = 4'b0010; data_v[1] = 8'hA7; apply();
    @(posedge clk); #1;
    check("mr_start", o_tx_start, 1);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    check("midreset_state", o_state, 0);
    req_v = '0; apply();
    @(negedge clk) rst_n = 1'b1;
    ptr_m = 0;
    @(posedge clk); #1;
    check("mr_idle", o_busy, 0);
    req_v = 4'b0100; data_v[2] = 8'h99; apply();
    serve(2, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
